// File: rtl/multdiv_sequencer_pkg.sv
// Shared opcode, ALU-op and exception constants plus the FSM state type for the X-stage multiply/divide sequencer.
package multdiv_sequencer_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int DEF_TIMEOUT       = 64;
  localparam int DEF_STATUS_REG    = 30;
  localparam int DEF_MULT_EXC_CODE = 4;
  localparam int DEF_DIV_EXC_CODE  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic f_is_md(input logic valid, input logic [4:0] opcode, input logic [4:0] aluop);
    return valid && (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/multdiv_sequencer.sv
// Starts the multi-cycle mul/div unit from X, stalls the front of the pipe while it works,
// then presents the result (or an rstatus exception write) for one cycle.
//
// state | meaning
// IDLE  | waiting for a mul/div in X; start pulse issued combinationally on detection
// BUSY  | unit working; counting cycles until md_ready or timeout
// DONE  | registered result presented for one cycle while the instruction moves to M
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int STATUS_REG    = DEF_STATUS_REG,
  parameter int MULT_EXC_CODE = DEF_MULT_EXC_CODE,
  parameter int DIV_EXC_CODE  = DEF_DIV_EXC_CODE
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_x_valid,
  input  logic [4:0]  i_x_opcode,
  input  logic [4:0]  i_x_aluop,
  input  logic [4:0]  i_x_rd,
  output logic        o_md_start_mult,
  output logic        o_md_start_div,
  input  logic        i_md_ready,
  input  logic        i_md_exception,
  input  logic [31:0] i_md_result,
  output logic        o_stall,
  output logic        o_bubble,
  output logic        o_res_valid,
  output logic [31:0] o_res_data,
  output logic [4:0]  o_res_rd,
  output logic        o_res_exc
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  md_state_e     r_state;
  md_state_e     w_next;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_rd;
  logic          r_is_div;
  logic [31:0]   r_res_data;
  logic [4:0]    r_res_rd;
  logic          r_res_exc;
  logic          w_is_md;
  logic          w_is_div;

  assign w_is_md  = f_is_md(i_x_valid, i_x_opcode, i_x_aluop);
  assign w_is_div = (i_x_aluop == ALU_DIV);

  assign o_res_data = r_res_data;
  assign o_res_rd   = r_res_rd;
  assign o_res_exc  = r_res_exc;

  always_comb begin
    w_next          = r_state;
    o_md_start_mult = 1'b0;
    o_md_start_div  = 1'b0;
    o_stall         = 1'b0;
    o_bubble        = 1'b0;
    o_res_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_md) begin
          o_md_start_mult = !w_is_div;
          o_md_start_div  = w_is_div;
          o_stall         = 1'b1;
          o_bubble        = 1'b1;
          w_next          = ST_BUSY;
        end
      end
      ST_BUSY: begin
        o_stall  = 1'b1;
        o_bubble = 1'b1;
        if (i_md_ready || (r_cnt == CNT_LAST)) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_res_valid = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_is_div   <= 1'b0;
      r_res_data <= '0;
      r_res_rd   <= '0;
      r_res_exc  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_is_md) begin
            r_rd     <= i_x_rd;
            r_is_div <= w_is_div;
            r_cnt    <= '0;
          end
        end
        ST_BUSY: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          // A ready in the final counted cycle still wins over the timeout.
          if (i_md_ready && !i_md_exception) begin
            r_res_data <= i_md_result;
            r_res_rd   <= r_rd;
            r_res_exc  <= 1'b0;
          end else if (i_md_ready || (r_cnt == CNT_LAST)) begin
            r_res_data <= r_is_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
            r_res_rd   <= 5'(STATUS_REG);
            r_res_exc  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed plus randomized checks of the mul/div sequencer against a cycle-budget reference model.
module tb_multdiv_sequencer;

  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic        x_valid;
  logic [4:0]  x_opcode;
  logic [4:0]  x_aluop;
  logic [4:0]  x_rd;
  logic        start_mult;
  logic        start_div;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        stall;
  logic        bubble;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_exc;

  int n_tests = 0;
  int n_fail  = 0;

  multdiv_sequencer #(.TIMEOUT(TMO)) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_x_valid      (x_valid),
    .i_x_opcode     (x_opcode),
    .i_x_aluop      (x_aluop),
    .i_x_rd         (x_rd),
    .o_md_start_mult(start_mult),
    .o_md_start_div (start_div),
    .i_md_ready     (md_ready),
    .i_md_exception (md_exception),
    .i_md_result    (md_result),
    .o_stall        (stall),
    .o_bubble       (bubble),
    .o_res_valid    (res_valid),
    .o_res_data     (res_data),
    .o_res_rd       (res_rd),
    .o_res_exc      (res_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic spec_is_md(input logic v, input logic [4:0] op, input logic [4:0] alu);
    return v && op == 5'b00000 && (alu == 5'b00110 || alu == 5'b00111);
  endfunction

  task automatic drive_random_non_md();
    x_valid  = 1'($urandom);
    x_opcode = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
    x_aluop  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(6, 7)) : 5'($urandom);
    x_rd     = 5'($urandom);
    if (spec_is_md(x_valid, x_opcode, x_aluop)) x_valid = 1'b0;
    md_ready     = 1'($urandom);
    md_exception = 1'($urandom);
    md_result    = $urandom;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_start"}, {30'd0, start_mult, start_div}, 32'd0);
    chk({tag, "_stall"}, {30'd0, stall, bubble}, 32'd0);
    chk({tag, "_resv"},  res_valid, 1'b0);
  endtask

  // delay: BUSY cycle (1-based) on which md_ready rises; > TMO means it never does.
  task automatic run_op(input logic is_div, input logic [4:0] rd, input int delay,
                        input logic exc, input logic [31:0] result, input logic ready_at_start);
    int          k;
    logic        timeout;
    logic        exp_exc;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    timeout  = (delay > TMO);
    k        = timeout ? TMO : delay;
    exp_exc  = timeout || exc;
    exp_data = exp_exc ? (is_div ? 32'd5 : 32'd4) : result;
    exp_rd   = exp_exc ? 5'd30 : rd;

    x_valid      = 1'b1;
    x_opcode     = 5'd0;
    x_aluop      = is_div ? 5'b00111 : 5'b00110;
    x_rd         = rd;
    md_ready     = ready_at_start;
    md_exception = 1'($urandom);
    md_result    = $urandom;
    #1;
    chk("start_mult", start_mult, !is_div);
    chk("start_div",  start_div,  is_div);
    chk("start_stall", {30'd0, stall, bubble}, 32'd3);
    chk("start_resv", res_valid, 1'b0);

    for (int i = 1; i <= k; i++) begin
      tick();
      md_ready     = (i == delay);
      md_exception = (i == delay) ? exc : 1'($urandom);
      md_result    = (i == delay) ? result : $urandom;
      x_rd         = 5'($urandom);
      #1;
      chk("busy_stall", {30'd0, stall, bubble}, 32'd3);
      chk("busy_start", {30'd0, start_mult, start_div}, 32'd0);
      chk("busy_resv",  res_valid, 1'b0);
    end

    tick();
    md_ready     = 1'($urandom);
    md_exception = 1'($urandom);
    md_result    = $urandom;
    #1;
    chk("done_resv",  res_valid, 1'b1);
    chk("done_data",  res_data, exp_data);
    chk("done_rd",    res_rd, exp_rd);
    chk("done_exc",   res_exc, exp_exc);
    chk("done_stall", {30'd0, stall, bubble}, 32'd0);
    chk("done_start", {30'd0, start_mult, start_div}, 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    x_valid = 1'b0; x_opcode = '0; x_aluop = '0; x_rd = '0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_quiet("rst");
    chk("rst_data", res_data, 32'd0);
    chk("rst_rd",   res_rd, 32'd0);
    chk("rst_exc",  res_exc, 1'b0);

    // add, x_valid=0 mul, md_ready=1 in IDLE
    x_valid = 1'b1; x_opcode = 5'd0; x_aluop = 5'd0; x_rd = 5'd4; md_ready = 1'b1;
    #1; chk_quiet("add");
    tick();
    x_valid = 1'b0; x_aluop = 5'b00110; md_ready = 1'b1;
    #1; chk_quiet("novalid_mul");
    tick();
    x_valid = 1'b1; x_opcode = 5'd3; x_aluop = 5'b00111;
    #1; chk_quiet("itype_div");
    tick();

    run_op(1'b0, 5'd3, 3, 1'b0, 32'd42, 1'b1);
    x_valid = 1'b0; md_ready = 1'b0;
    tick();
    run_op(1'b1, 5'd5, 2, 1'b1, 32'h1234, 1'b0);
    run_op(1'b0, 5'd7, 100, 1'b0, 32'hdead, 1'b0);
    run_op(1'b0, 5'd9, TMO, 1'b0, 32'hbeef, 1'b0);
    run_op(1'b0, 5'd11, 2, 1'b0, 32'h11, 1'b0);
    run_op(1'b1, 5'd12, 1, 1'b0, 32'h22, 1'b1);
    run_op(1'b1, 5'd13, 100, 1'b0, 32'h33, 1'b0);

    // reset during BUSY
    x_valid = 1'b1; x_opcode = 5'd0; x_aluop = 5'b00110; x_rd = 5'd6; md_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; x_valid = 1'b0; md_ready = 1'b1; md_result = 32'h77;
    #1;
    chk_quiet("midrst");
    chk("midrst_data", res_data, 32'd0);
    chk("midrst_exc",  res_exc, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk_quiet("midrst_idle");
    end
    tick();
    run_op(1'b0, 5'd6, 2, 1'b0, 32'h99, 1'b0);

    for (int n = 0; n < 25; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive_random_non_md();
        #1;
        chk_quiet("rnd_idle");
        tick();
      end
      run_op(1'($urandom), 5'($urandom), $urandom_range(1, TMO + 2), 1'($urandom),
             $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
